chaoentsrc_multi: RTL and testbench



---
 rtl/chaoentsrc_multi.sv | 152 +++++++++++++++
 tb/tb_chaoentsrc_multi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chaoentsrc_multi.sv
// chaoentsrc_multi: multi-channel chaotic entropy collector.
// Edge-count parity sampling, repetition health test, word packing.
module chaoentsrc_multi #(
    parameter int NUM_CH        = 4,
    parameter int RNG_WIDTH     = 32,
    parameter int SAMPLE_PERIOD = 16,
    parameter int CNT_WIDTH     = 4,
    parameter int REP_LIMIT     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_en,
    input  logic [NUM_CH-1:0]    i_chao,
    input  logic                 i_ready,
    input  logic                 i_clr_fail,
    output logic [RNG_WIDTH-1:0] o_rnd,
    output logic                 o_valid,
    output logic [NUM_CH-1:0]    o_osc_sel,
    output logic                 o_health_fail
);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int BW = (RNG_WIDTH > 2) ? $clog2(RNG_WIDTH) : 1;
    localparam int RW = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, FILL, HOLD, FAIL} state_t;

    state_t state_q, state_d;

    logic [NUM_CH-1:0]    sync1, sync2, sync3;
    logic [NUM_CH-1:0]    edge_det;
    logic [CNT_WIDTH-1:0] cnt [NUM_CH];
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_cnt;
    logic [RW-1:0]        rep_cnt, rep_nxt;
    logic                 prev_bit;
    logic                 raw_bit;
    logic                 sample;
    logic                 abort;
    logic                 fail_hit;
    logic                 last_bit;

    assign edge_det = sync2 & ~sync3;
    assign sample   = i_en && (timer == TW'(SAMPLE_PERIOD - 1));
    assign abort    = !i_en && (state_q != FAIL);
    assign last_bit = (bit_cnt == BW'(RNG_WIDTH - 1));
    assign fail_hit = sample && (rep_nxt == RW'(REP_LIMIT));

    always_comb begin
        raw_bit = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++)
            raw_bit = raw_bit ^ cnt[ch][0];
    end

    // First sample after reset or IDLE sees rep_cnt == 0
    always_comb begin
        if (rep_cnt == '0 || raw_bit != prev_bit)
            rep_nxt = RW'(1);
        else if (rep_cnt == RW'(REP_LIMIT))
            rep_nxt = rep_cnt;
        else
            rep_nxt = rep_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort)
            state_d = IDLE;
        else begin
            unique case (state_q)
                IDLE: if (i_en) state_d = FILL;
                FILL: begin
                    if (fail_hit)
                        state_d = FAIL;
                    else if (sample && last_bit)
                        state_d = HOLD;
                end
                HOLD: begin
                    if (fail_hit)
                        state_d = FAIL;
                    else if (i_ready)
                        state_d = FILL;
                end
                FAIL: if (!fail_hit && i_clr_fail) state_d = FILL;
            endcase
        end
    end

    always_comb begin
        o_valid       = (state_q == HOLD);
        o_health_fail = (state_q == FAIL);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            for (int ch = 0; ch < NUM_CH; ch++)
                cnt[ch] <= '0;
        end else begin
            sync1 <= i_chao;
            sync2 <= sync1;
            sync3 <= sync2;
            for (int ch = 0; ch < NUM_CH; ch++)
                if (i_en && edge_det[ch])
                    cnt[ch] <= cnt[ch] + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            timer     <= '0;
            bit_cnt   <= '0;
            rep_cnt   <= '0;
            prev_bit  <= 1'b0;
            o_osc_sel <= '0;
            o_rnd     <= '0;
        end else begin
            if (abort)
                timer <= '0;
            else if (i_en)
                timer <= sample ? '0 : timer + 1'b1;

            if (abort)
                bit_cnt <= '0;
            else if (state_q == FILL && sample)
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            else if (state_q != FILL)
                bit_cnt <= '0;

            if (abort)
                rep_cnt <= '0;
            else if (sample) begin
                rep_cnt  <= rep_nxt;
                prev_bit <= raw_bit;
            end

            if (sample)
                o_osc_sel <= sync2;

            if (state_q == FILL && sample)
                o_rnd <= {o_rnd[RNG_WIDTH-2:0], raw_bit};
        end
    end
endmodule

// File: tb/tb_chaoentsrc_multi.sv
// tb_chaoentsrc_multi: directed vectors, corner sequences and a
// randomized run against a behavioural model of the collector.
module tb_chaoentsrc_multi;
    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int SP  = 8;
    localparam int REP = 4;

    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_HOLD = 2;
    localparam int M_FAIL = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en, rdy, clr;
    logic [NCH-1:0] chao;
    logic [W-1:0]   rnd;
    logic           valid;
    logic [NCH-1:0] osc;
    logic           hfail;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chaoentsrc_multi #(
        .NUM_CH(NCH),
        .RNG_WIDTH(W),
        .SAMPLE_PERIOD(SP),
        .CNT_WIDTH(4),
        .REP_LIMIT(REP)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_en(en),
        .i_chao(chao),
        .i_ready(rdy),
        .i_clr_fail(clr),
        .o_rnd(rnd),
        .o_valid(valid),
        .o_osc_sel(osc),
        .o_health_fail(hfail)
    );

    typedef struct {
        logic [31:0] masks;
        logic [7:0]  rnd;
        logic        valid;
        logic        fail;
    } vec_t;

    vec_t vecs[9];

    // Behavioural model: raw bit is the parity of all edges seen so far
    bit [NCH-1:0] m_d0, m_d1, m_d2;
    int           m_total, m_phase, m_nbits, m_run, m_mode;
    bit           m_prev;
    logic [W-1:0] m_word;
    logic [NCH-1:0] m_osc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        en    = 1'b0;
        rdy   = 1'b0;
        clr   = 1'b0;
        chao  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_periods(input logic [31:0] masks, input int nper);
        logic [3:0] m;
        for (int p = 0; p < nper; p++) begin
            m = masks[31-4*(p%8) -: 4];
            for (int c = 0; c < SP; c++) begin
                en   = 1'b1;
                chao = (c >= 1 && c <= 3) ? m : '0;
                @(negedge clk);
            end
        end
        chao = '0;
    endtask

    task automatic model_reset();
        m_d0 = '0; m_d1 = '0; m_d2 = '0;
        m_total = 0; m_phase = 0; m_nbits = 0; m_run = 0;
        m_mode = M_IDLE; m_prev = 1'b0; m_word = '0; m_osc = '0;
    endtask

    task automatic model_step(input bit e_n, input bit [NCH-1:0] ch,
                              input bit r, input bit c);
        bit [NCH-1:0] edg;
        bit smp, b, hit;
        int nrun;
        edg  = m_d1 & ~m_d2;
        smp  = e_n && (m_phase == SP - 1);
        b    = (m_total % 2) == 1;
        nrun = m_run;
        hit  = 1'b0;
        if (smp) begin
            if (m_run == 0 || b != m_prev) nrun = 1;
            else nrun = (m_run + 1 > REP) ? REP : m_run + 1;
            hit = (nrun >= REP);
        end
        if (e_n) m_total += $countones(edg);
        if (!e_n && m_mode != M_FAIL) begin
            m_mode = M_IDLE; m_phase = 0; m_run = 0; m_nbits = 0;
        end else begin
            if (e_n) m_phase = (m_phase + 1) % SP;
            if (smp) begin
                m_run = nrun; m_prev = b; m_osc = m_d1;
            end
            case (m_mode)
                M_IDLE: m_mode = M_FILL;
                M_FILL: if (smp) begin
                    m_word = {m_word[W-2:0], b};
                    m_nbits++;
                    if (hit) m_mode = M_FAIL;
                    else if (m_nbits == W) begin
                        m_mode = M_HOLD; m_nbits = 0;
                    end
                end
                M_HOLD: begin
                    if (hit) m_mode = M_FAIL;
                    else if (r) begin m_mode = M_FILL; m_nbits = 0; end
                end
                default: if (!hit && c) begin
                    m_mode = M_FILL; m_nbits = 0;
                end
            endcase
        end
        m_d2 = m_d1; m_d1 = m_d0; m_d0 = ch;
    endtask

    initial begin
        int bad;
        vecs[0] = '{32'h1111_1111, 8'hAA, 1'b1, 1'b0};
        vecs[1] = '{32'h3333_3333, 8'h00, 1'b0, 1'b1};
        vecs[2] = '{32'h7777_7777, 8'hAA, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0000, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{32'h1010_1010, 8'hCC, 1'b1, 1'b0};
        vecs[5] = '{32'h1101_0011, 8'h9D, 1'b1, 1'b0};
        vecs[6] = '{32'h1100_0000, 8'h10, 1'b0, 1'b1};
        vecs[7] = '{32'h3131_3131, 8'h66, 1'b1, 1'b0};
        vecs[8] = '{32'hFFFF_FFFF, 8'h00, 1'b0, 1'b1};

        // Reset with chao toggling, then idle with en low
        rst_n = 1'b0; en = 1'b0; rdy = 1'b0; clr = 1'b0; chao = '0;
        for (int i = 0; i < 10; i++) begin
            chao = NCH'($urandom);
            @(negedge clk);
        end
        chk("rst_rnd", rnd, 0);
        chk("rst_valid", valid, 0);
        chk("rst_osc", osc, 0);
        chk("rst_fail", hfail, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            chao = NCH'($urandom);
            @(negedge clk);
            if (valid !== 1'b0) bad++;
        end
        chk("idle_valid", bad, 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            run_periods(vecs[i].masks, 8);
            chk($sformatf("v%0d_rnd", i), rnd, vecs[i].rnd);
            chk($sformatf("v%0d_valid", i), valid, vecs[i].valid);
            chk($sformatf("v%0d_fail", i), hfail, vecs[i].fail);
        end

        // Backpressure, handshake, refill and async reset in HOLD
        do_reset();
        run_periods(32'h1111_1111, 8);
        run_periods(32'h1111_1111, 25);
        chk("bp_valid", valid, 1);
        chk("bp_rnd", rnd, 8'hAA);
        rdy = 1'b1;
        @(negedge clk);
        chk("hs_valid_fall", valid, 0);
        rdy = 1'b0;
        repeat (SP - 1) @(negedge clk);
        run_periods(32'h1111_1111, 6);
        chk("refill_early", valid, 0);
        run_periods(32'h1111_1111, 1);
        chk("refill_valid", valid, 1);
        chk("refill_rnd", rnd, 8'hAA);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", valid, 0);
        chk("async_rnd", rnd, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Health failure, clear, re-trip, failure-wins, en low in FAIL
        do_reset();
        run_periods(32'h0000_0000, 8);
        chk("hf_set", hfail, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("hf_clear", hfail, 0);
        repeat (SP - 1) @(negedge clk);
        chk("hf_retrip", hfail, 1);
        chk("hf_valid", valid, 0);
        repeat (SP - 1) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("hf_wins", hfail, 1);
        en = 1'b0;
        repeat (10) @(negedge clk);
        chk("hf_en_low", hfail, 1);

        // Enable abort after 5 bits
        do_reset();
        run_periods(32'h1111_1111, 5);
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("ab_valid_idle", valid, 0);
        run_periods(32'h1111_1111, 7);
        chk("ab_valid_7", valid, 0);
        run_periods(32'h1111_1111, 1);
        chk("ab_valid_8", valid, 1);
        chk("ab_rnd", rnd, 8'h55);
        chk("ab_fail", hfail, 0);

        // Randomized run against the model
        do_reset();
        model_reset();
        en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (en) begin
                if ($urandom_range(0, 299) == 0) en = 1'b0;
            end else if ($urandom_range(0, 19) == 0) en = 1'b1;
            chao = NCH'($urandom);
            rdy  = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 19) == 0);
            model_step(en, chao, rdy, clr);
            @(negedge clk);
            chk("rand_rnd", rnd, m_word);
            chk("rand_valid", valid, m_mode == M_HOLD);
            chk("rand_fail", hfail, m_mode == M_FAIL);
            chk("rand_osc", osc, m_osc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
